// File: rtl/sync_updown_counter.sv
// Parametrised up/down counter with clear, clamped parallel load, wrap or
// saturate at the limits, and terminal-count / overflow / underflow flags.
module sync_updown_counter #(
  parameter int unsigned         WIDTH     = 8,
  parameter logic [WIDTH-1:0]    MAX_COUNT = {WIDTH{1'b1}},
  parameter bit                  SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] count_p0;
  logic             ovf_p0;
  logic             unf_p0;

  logic [WIDTH-1:0] count_nxt;
  logic             ovf_nxt;
  logic             unf_nxt;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_COUNT) ? MAX_COUNT : v;
  endfunction

  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] c);
    if (c >= MAX_COUNT) return SATURATE ? MAX_COUNT : '0;
    return c + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] c);
    if (c == '0) return SATURATE ? '0 : MAX_COUNT;
    return c - WIDTH'(1);
  endfunction

  // Action select: clear > load > enabled step > hold
  always_comb begin
    count_nxt = count_p0;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    if (clear) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = clamp_load(load_value);
    end else if (enable) begin
      if (up_down) begin
        count_nxt = step_up(count_p0);
        ovf_nxt   = (count_p0 == MAX_COUNT);
      end else begin
        count_nxt = step_down(count_p0);
        unf_nxt   = (count_p0 == '0);
      end
    end
  end

  // Stage p0: registered count and one-cycle flag pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_p0 <= '0;
      ovf_p0   <= 1'b0;
      unf_p0   <= 1'b0;
    end else begin
      count_p0 <= count_nxt;
      ovf_p0   <= ovf_nxt;
      unf_p0   <= unf_nxt;
    end
  end

  assign count     = count_p0;
  assign overflow  = ovf_p0;
  assign underflow = unf_p0;
  assign tc        = (up_down & (count_p0 == MAX_COUNT)) | (~up_down & (count_p0 == '0));

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed bench for sync_updown_counter: three instances (4-bit wrap, 4-bit
// saturate, 8-bit default) share control inputs and are scored against a model.
module tb_sync_updown_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable, up_down, clear, load;
  logic [3:0] lv4;
  logic [7:0] lv8;

  logic [3:0] count_w, count_s;
  logic [7:0] count_d;
  logic       tc_w, tc_s, tc_d;
  logic       ovf_w, ovf_s, ovf_d;
  logic       unf_w, unf_s, unf_d;

  always #5 clk = ~clk;

  sync_updown_counter #(.WIDTH(4), .MAX_COUNT(4'd9), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_value(lv4), .count(count_w), .tc(tc_w),
    .overflow(ovf_w), .underflow(unf_w));

  sync_updown_counter #(.WIDTH(4), .MAX_COUNT(4'd9), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_value(lv4), .count(count_s), .tc(tc_s),
    .overflow(ovf_s), .underflow(unf_s));

  sync_updown_counter dut_d (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_value(lv8), .count(count_d), .tc(tc_d),
    .overflow(ovf_d), .underflow(unf_d));

  typedef struct {
    string tag;
    int    cw, cs, cd;
    bit    ow, os, od;
    bit    uw, us, ud;
  } exp_t;

  exp_t sb[$];
  int   cnt_w, cnt_s, cnt_d;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference behaviour for one clock edge
  function automatic void model(input int c, input int maxc, input bit sat, input int lv,
                                output int nc, output bit o, output bit u);
    nc = c; o = 0; u = 0;
    if (clear) nc = 0;
    else if (load) nc = (lv > maxc) ? maxc : lv;
    else if (enable && up_down) begin
      if (c == maxc) begin o = 1; nc = sat ? maxc : 0; end
      else nc = c + 1;
    end else if (enable) begin
      if (c == 0) begin u = 1; nc = sat ? 0 : maxc; end
      else nc = c - 1;
    end
  endfunction

  function automatic bit tc_model(input int c, input int maxc);
    return up_down ? (c == maxc) : (c == 0);
  endfunction

  task automatic check_tc(input string tag);
    chk({tag, ".tc_w"}, 32'(tc_w), 32'(tc_model(cnt_w, 9)));
    chk({tag, ".tc_s"}, 32'(tc_s), 32'(tc_model(cnt_s, 9)));
    chk({tag, ".tc_d"}, 32'(tc_d), 32'(tc_model(cnt_d, 255)));
  endtask

  task automatic cycle(input string tag);
    exp_t e, g;
    int nc; bit o, u;
    e.tag = tag;
    model(cnt_w, 9, 0, int'(lv4), nc, o, u);   cnt_w = nc; e.cw = nc; e.ow = o; e.uw = u;
    model(cnt_s, 9, 1, int'(lv4), nc, o, u);   cnt_s = nc; e.cs = nc; e.os = o; e.us = u;
    model(cnt_d, 255, 0, int'(lv8), nc, o, u); cnt_d = nc; e.cd = nc; e.od = o; e.ud = u;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk({g.tag, ".count_w"}, 32'(count_w), 32'(g.cw));
    chk({g.tag, ".count_s"}, 32'(count_s), 32'(g.cs));
    chk({g.tag, ".count_d"}, 32'(count_d), 32'(g.cd));
    chk({g.tag, ".ovf_w"}, 32'(ovf_w), 32'(g.ow));
    chk({g.tag, ".ovf_s"}, 32'(ovf_s), 32'(g.os));
    chk({g.tag, ".ovf_d"}, 32'(ovf_d), 32'(g.od));
    chk({g.tag, ".unf_w"}, 32'(unf_w), 32'(g.uw));
    chk({g.tag, ".unf_s"}, 32'(unf_s), 32'(g.us));
    chk({g.tag, ".unf_d"}, 32'(unf_d), 32'(g.ud));
    check_tc(g.tag);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".count_w"}, 32'(count_w), 0);
    chk({tag, ".count_s"}, 32'(count_s), 0);
    chk({tag, ".count_d"}, 32'(count_d), 0);
    chk({tag, ".flags"}, 32'({ovf_w, ovf_s, ovf_d, unf_w, unf_s, unf_d}), 0);
  endtask

  initial begin
    reset = 1'b0; enable = 0; up_down = 1; clear = 0; load = 0; lv4 = 0; lv8 = 0;
    cnt_w = 0; cnt_s = 0; cnt_d = 0;
    #12;
    check_all_zero("reset");
    check_tc("reset");
    up_down = 0;
    #1;
    check_tc("tc_follows_ud");
    up_down = 1;
    @(negedge clk);
    reset = 1'b1;

    // Wrap up: 11 up steps
    enable = 1; up_down = 1;
    for (int i = 0; i < 11; i++) cycle($sformatf("up%0d", i));

    // Wrap down from 0
    enable = 0; clear = 1;
    cycle("clear");
    clear = 0; enable = 1; up_down = 0;
    #1;
    check_tc("tc_at0_down");
    for (int i = 0; i < 2; i++) cycle($sformatf("down%0d", i));

    // Saturate at the top
    enable = 0; load = 1; lv4 = 4'd9; lv8 = 8'd254;
    cycle("load9");
    load = 0; enable = 1; up_down = 1;
    for (int i = 0; i < 3; i++) cycle($sformatf("satup%0d", i));

    // Saturate at zero: down steps from 0
    enable = 0; clear = 1;
    cycle("clear2");
    clear = 0; enable = 1; up_down = 0;
    for (int i = 0; i < 2; i++) cycle($sformatf("satdn%0d", i));

    // Priority and clamp
    load = 1; lv4 = 4'd15; lv8 = 8'd200; enable = 1; up_down = 1;
    cycle("load_clamp");
    clear = 1;
    cycle("clear_over_load");
    clear = 0; load = 0;

    // Async reset mid-count
    enable = 1; up_down = 1;
    for (int i = 0; i < 5; i++) cycle($sformatf("pre%0d", i));
    chk("at5", 32'(count_w), 5);
    #2;
    reset = 1'b0;
    #1;
    cnt_w = 0; cnt_s = 0; cnt_d = 0;
    check_all_zero("async_reset");
    #2;
    reset = 1'b1;
    cycle("post_reset");
    chk("post_reset_is1", 32'(count_w), 1);

    // Default instance across its top limit
    enable = 0; load = 1; lv8 = 8'd254; lv4 = 4'd3;
    cycle("load254");
    load = 0; enable = 1; up_down = 1;
    for (int i = 0; i < 2; i++) cycle($sformatf("def_up%0d", i));
    chk("def_wrap0", 32'(count_d), 0);
    chk("def_ovf", 32'(ovf_d), 1);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sync_updown_counter.md
# sync_updown_counter

Parametrised synchronous up/down counter, the next generation of the team's single-width up counter. Adds configurable width and modulus, direction control, synchronous clear and parallel load, wrap or saturate mode, and terminal-count / overflow / underflow flags. Used as the general-purpose counting primitive for timers, address generators and event counters. Driven and checked through the team's interface/test/testbench environment.

## Interface

- WIDTH, 8, counter width in bits (≥2).
- MAX_COUNT, 2**WIDTH-1, highest legal count value; must satisfy 1 ≤ MAX_COUNT ≤ 2**WIDTH-1.
- SATURATE, 0, 0 = wrap at the limits, 1 = hold at the limits.

Ports:

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  count-step enable.
- up_down  input  1  direction: 1 = up, 0 = down.
- clear  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_value  input  WIDTH  value to load.
- count  output  WIDTH  current count (registered).
- tc  output  1  terminal count (combinational from count and up_down).
- overflow  output  1  one-cycle pulse: up step attempted at MAX_COUNT (registered).
- underflow  output  1  one-cycle pulse: down step attempted at 0 (registered).

## Operation

- Reset (reset = 0) forces count = 0, overflow = 0, underflow = 0 immediately, independent of clk.
- Each rising clk edge applies exactly one action, in this priority order:
  - **clear**: count ← 0.
  - **load**: count ← min(load_value, MAX_COUNT); values above MAX_COUNT clamp to MAX_COUNT.
  - **enable, up_down = 1**:
    - count < MAX_COUNT: count ← count+1.
    - count = MAX_COUNT: count ← 0 if SATURATE = 0, else hold.
  - **enable, up_down = 0**:
    - count > 0: count ← count−1.
    - count = 0: count ← MAX_COUNT if SATURATE = 0, else hold.
  - **otherwise**: hold.
- overflow ← 1 only when the selected action is an enabled up step taken at count = MAX_COUNT; 0 on every other edge. This applies in both modes.
- underflow ← 1 only when the selected action is an enabled down step taken at count = 0; 0 on every other edge. This applies in both modes.
- clear or load in the same cycle as enable suppresses the step and both flags.
- tc = (up_down & count==MAX_COUNT) | (~up_down & count==0). tc follows up_down changes combinationally.
- All arithmetic is WIDTH bits wide. Comparisons are unsigned. No intermediate value exceeds MAX_COUNT.

## Timing

- Latency: count, overflow and underflow reflect an input one clk edge after it is sampled.
- An overflow/underflow pulse coincides with the cycle in which count shows the wrapped (or held) value.
- Reset assertion mid-operation clears all registered outputs within the same cycle, without waiting for clk.
- After reset deassertion, the first rising clk edge with reset = 1 performs a normal action.
- Inputs that change between edges have no effect. tc is the only output that is not registered.
- No handshake. enable may be held high continuously, giving one step per clock.

## Test plan

(WIDTH = 4, MAX_COUNT = 9 unless noted.)

- **Wrap up:** SATURATE = 0, reset then enable = 1, up_down = 1 for 11 clocks -> count 1..9, 0, 1. tc = 1 while count = 9. overflow pulses exactly once, in the cycle count = 0.
- **Wrap down:** from count = 0, enable = 1, up_down = 0 for 2 clocks -> count 9, then 8. underflow pulses once, with count = 9. tc = 1 at count 0 before the first edge.
- **Saturate:** SATURATE = 1, load 9 then up for 3 clocks -> count stays 9 and overflow pulses on all 3 cycles. Down from 0 -> count stays 0 and underflow pulses.
- **Priority and clamp:** load = 1, load_value = 15, enable = 1 -> count = 9, no flag. clear = 1 and load = 1 together -> count = 0.
- **Async reset mid-count:** counting at count = 5, drop reset between edges -> count = 0 and flags = 0 immediately. Release reset with enable held -> count = 1 after the first edge.
- **Default params:** WIDTH = 8, MAX_COUNT = 255, up from 254 for 2 clocks -> count 255, then 0, with overflow = 1.
